// File: rtl/mem_port_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and transaction owner.
package mem_port_arb_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  localparam logic ARB_OWN_IF  = 1'b0;
  localparam logic ARB_OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_port_arb_pick.sv
// Winner select between IF and LSU, with the IF starvation counter that forces
// an IF win after STARV_MAX consecutive lost arbitrations.
module mem_port_arb_pick
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned STARV_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_flush,
  input  logic lsu_req,
  input  logic arb,
  output logic winner,
  output logic valid
);

  localparam int unsigned CNT_W = $clog2(STARV_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARV_MAX);

  logic [CNT_W-1:0] starv_q;
  logic [CNT_W-1:0] starv_d;
  logic             if_elig;
  logic             if_forced;

  always_comb begin
    if_elig   = if_req & ~if_flush;
    if_forced = if_elig & (starv_q == CNT_MAX);
    valid     = if_elig | lsu_req;
    winner    = (lsu_req & ~if_forced) ? ARB_OWN_LSU : ARB_OWN_IF;

    starv_d = starv_q;
    if (!if_req) begin
      starv_d = '0;
    end else if (arb && valid) begin
      if (winner == ARB_OWN_IF) begin
        starv_d = '0;
      end else if (if_elig && (starv_q != CNT_MAX)) begin
        starv_d = starv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starv_q <= '0;
    end else begin
      starv_q <= starv_d;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Single memory port shared by instruction fetch and the LSU: one transaction
// at a time (address handshake, then response), with flush-drop and hazard flags.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned STARV_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err,
  output logic                arb2ac_if_hazard,
  output logic                arb2ac_lsu_hazard
);

  logic [1:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic                drop_q, drop_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;

  logic hs, done, arb, if_sup, pick_winner, pick_valid, win_lsu;

  mem_port_arb_pick #(
    .STARV_MAX(STARV_MAX)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .if_flush(if_flush),
    .lsu_req (lsu_req),
    .arb     (arb),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  always_comb begin
    hs      = (state_q == ARB_ADDR) & mem_valid_q & mem_ready;
    done    = (state_q == ARB_DATA) & mem_rvalid;
    arb     = (state_q == ARB_IDLE) | done;
    win_lsu = (pick_winner == ARB_OWN_LSU);
    // A flush arriving in the grant/response cycle itself suppresses that pulse too.
    if_sup  = drop_q | if_flush;

    if_gnt     = hs & (owner_q == ARB_OWN_IF) & ~if_sup & ~rst;
    lsu_gnt    = hs & (owner_q == ARB_OWN_LSU) & ~rst;
    if_rvalid  = done & (owner_q == ARB_OWN_IF) & ~if_sup & ~rst;
    lsu_rvalid = done & (owner_q == ARB_OWN_LSU) & ~rst;
    resp_rdata = (done & ~rst) ? mem_rdata : '0;
    resp_err   = done & ~rst & mem_err;

    arb2ac_if_hazard  = if_req & ~if_flush & ~if_rvalid;
    arb2ac_lsu_hazard = lsu_req & ~lsu_rvalid;

    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    if ((state_q != ARB_IDLE) && (owner_q == ARB_OWN_IF) && if_flush) begin
      drop_d = 1'b1;
    end

    case (state_q)
      ARB_IDLE: ;
      ARB_ADDR: begin
        if (hs) begin
          state_d     = ARB_DATA;
          mem_valid_d = 1'b0;
        end
      end
      ARB_DATA: begin
        if (done) begin
          state_d = ARB_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Arbitration in IDLE or on the completing DATA cycle (back-to-back issue).
    if (arb && pick_valid) begin
      state_d     = ARB_ADDR;
      owner_d     = pick_winner;
      mem_valid_d = 1'b1;
      mem_we_d    = win_lsu & lsu_we;
      mem_addr_d  = win_lsu ? lsu_addr : if_addr;
      mem_wdata_d = win_lsu ? lsu_wdata : '0;
      mem_wstrb_d = (win_lsu & lsu_we) ? lsu_wstrb : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWN_IF;
      drop_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  mem_rvalid_only_in_data: assert property (
    @(posedge clk) disable iff (rst) mem_rvalid |-> (state_q == ARB_DATA)
  );

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: requester and memory models, expected
// transactions queued at issue and checked at handshake and response.
module tb_mem_port_arb;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STARV_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic        arb2ac_if_hazard, arb2ac_lsu_hazard;

  mem_port_arb #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .STARV_MAX(STARV_MAX)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_flush         (if_flush),
    .if_gnt           (if_gnt),
    .if_rvalid        (if_rvalid),
    .lsu_req          (lsu_req),
    .lsu_we           (lsu_we),
    .lsu_addr         (lsu_addr),
    .lsu_wdata        (lsu_wdata),
    .lsu_wstrb        (lsu_wstrb),
    .lsu_gnt          (lsu_gnt),
    .lsu_rvalid       (lsu_rvalid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .mem_err          (mem_err),
    .arb2ac_if_hazard (arb2ac_if_hazard),
    .arb2ac_lsu_hazard(arb2ac_lsu_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        own_lsu;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt_exp;
    logic        rv_exp;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } lreq_t;

  exp_t  exp_q[$];
  exp_t  cur;
  logic  cur_valid;
  lreq_t lsu_list[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // sampled state from the last monitor pass
  logic        s_hs, s_rv, s_if_gnt, s_lsu_gnt, s_prev_stall, s_b2b;
  logic [31:0] s_addr;

  // memory model
  int          stall_left;
  int          resp_lat;
  logic        mp_valid;
  int          mp_cnt;
  logic [31:0] mp_data;
  logic        mp_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic rd_err(input logic [31:0] a);
    return a[11:8] == 4'h3;
  endfunction

  task automatic push_if(input logic [31:0] a, input logic g, input logic rv);
    exp_t e;
    e.own_lsu = 1'b0; e.we = 1'b0; e.addr = a; e.wdata = '0; e.wstrb = '0;
    e.gnt_exp = g; e.rv_exp = rv; e.rdata = rd_fn(a); e.err = rd_err(a);
    exp_q.push_back(e);
  endtask

  task automatic push_lsu(input lreq_t r);
    exp_t e;
    e.own_lsu = 1'b1; e.we = r.we; e.addr = r.addr; e.wdata = r.wdata;
    e.wstrb = r.we ? r.wstrb : 4'h0;
    e.gnt_exp = 1'b1; e.rv_exp = 1'b1; e.rdata = rd_fn(r.addr); e.err = rd_err(r.addr);
    exp_q.push_back(e);
  endtask

  task automatic lsu_load();
    lreq_t r;
    r = lsu_list.pop_front();
    lsu_req = 1'b1; lsu_we = r.we; lsu_addr = r.addr; lsu_wdata = r.wdata; lsu_wstrb = r.wstrb;
  endtask

  task automatic monitor();
    logic hs, rv, e_ifg, e_lsug, e_ifrv, e_lsurv;
    hs = mem_valid & mem_ready;
    rv = mem_rvalid;
    e_ifg = 1'b0; e_lsug = 1'b0; e_ifrv = 1'b0; e_lsurv = 1'b0;
    if (rst) begin
      check_eq("pulses_in_rst", {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid}, 4'h0);
      s_hs = 1'b0; s_rv = 1'b0; s_if_gnt = 1'b0; s_lsu_gnt = 1'b0;
      s_prev_stall = 1'b0; s_b2b = 1'b0; s_addr = '0;
    end else begin
      if (rv) begin
        check_eq("rsp_outstanding", cur_valid, 1'b1);
        e_ifrv  = cur_valid & ~cur.own_lsu & cur.rv_exp;
        e_lsurv = cur_valid & cur.own_lsu & cur.rv_exp;
        if (cur_valid && cur.rv_exp) begin
          check_eq("resp_rdata", resp_rdata, cur.rdata);
          check_eq("resp_err", resp_err, cur.err);
        end
        cur_valid = 1'b0;
      end
      if (hs) begin
        check_eq("req_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          check_eq("mem_we", mem_we, cur.we);
          check_eq("mem_addr", mem_addr, cur.addr);
          check_eq("mem_wdata", mem_wdata, cur.wdata);
          check_eq("mem_wstrb", mem_wstrb, cur.wstrb);
          e_ifg  = ~cur.own_lsu & cur.gnt_exp;
          e_lsug = cur.own_lsu & cur.gnt_exp;
        end
      end
      check_eq("if_gnt", if_gnt, e_ifg);
      check_eq("lsu_gnt", lsu_gnt, e_lsug);
      check_eq("if_rvalid", if_rvalid, e_ifrv);
      check_eq("lsu_rvalid", lsu_rvalid, e_lsurv);
      check_eq("if_hazard", arb2ac_if_hazard, if_req & ~if_flush & ~e_ifrv);
      check_eq("lsu_hazard", arb2ac_lsu_hazard, lsu_req & ~e_lsurv);
      if (s_prev_stall) begin
        check_eq("stall_valid_held", mem_valid, 1'b1);
        check_eq("stall_addr_held", mem_addr, s_addr);
      end
      if (s_b2b) check_eq("b2b_no_bubble", mem_valid, 1'b1);
      s_prev_stall = mem_valid & ~mem_ready;
      s_addr       = mem_addr;
      s_b2b        = rv & ((if_req & ~if_flush) | lsu_req);
      s_hs = hs; s_rv = rv; s_if_gnt = if_gnt; s_lsu_gnt = lsu_gnt;
    end
  endtask

  task automatic models();
    if (s_if_gnt) if_req = 1'b0;
    if (s_lsu_gnt) begin
      if (lsu_list.size() != 0) lsu_load();
      else lsu_req = 1'b0;
    end
    if (s_prev_stall && stall_left > 0) stall_left--;
    mem_ready = (stall_left == 0);
    if (s_rv) mp_valid = 1'b0;
    if (s_hs) begin
      mp_valid = 1'b1; mp_cnt = resp_lat - 1;
      mp_data = rd_fn(s_addr); mp_err = rd_err(s_addr);
    end
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    if (mp_valid) begin
      if (mp_cnt == 0) begin
        mem_rvalid = 1'b1; mem_rdata = mp_data; mem_err = mp_err;
      end else begin
        mp_cnt--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    models();
  endtask

  task automatic drain(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exp_q.size() == 0 && !cur_valid) begin
        got = 1'b1;
        break;
      end
    end
    check_eq(tag, got, 1'b1);
    tick();
  endtask

  task automatic wait_hs(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (s_hs) begin
        got = 1'b1;
        break;
      end
    end
    check_eq(tag, got, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pulses"}, {if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, resp_err}, 5'h0);
    check_eq({tag, "_rdata"}, resp_rdata, 32'h0);
    check_eq({tag, "_mem_ctl"}, {mem_valid, mem_we, mem_wstrb}, 6'h0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'h0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check_eq({tag, "_hazards"}, {arb2ac_if_hazard, arb2ac_lsu_hazard}, 2'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    lreq_t r;
    rst = 1'b1;
    if_req = 0; if_addr = '0; if_flush = 0;
    lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_ready = 1; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    s_hs = 0; s_rv = 0; s_if_gnt = 0; s_lsu_gnt = 0; s_prev_stall = 0; s_b2b = 0; s_addr = '0;
    stall_left = 0; resp_lat = 1; mp_valid = 0; mp_cnt = 0; mp_data = '0; mp_err = 0;
    cur_valid = 0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // lone IF read, response two cycles after the handshake
    resp_lat = 2;
    push_if(32'h100, 1'b1, 1'b1);
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    check_eq("if_lat_valid", mem_valid, 1'b1);
    check_eq("if_lat_addr", mem_addr, 32'h100);
    drain("drain_lone_if");

    // simultaneous requests: LSU write first, then IF back-to-back
    resp_lat = 1;
    r.we = 1'b1; r.addr = 32'h200; r.wdata = 32'hCAFE_F00D; r.wstrb = 4'hF;
    push_lsu(r);
    push_if(32'h104, 1'b1, 1'b1);
    lsu_list.push_back(r);
    lsu_load();
    if_req = 1'b1; if_addr = 32'h104;
    drain("drain_b2b");

    // starvation: IF wins the 9th arbitration against a continuous LSU stream
    for (int k = 0; k < 11; k++) begin
      r.we    = k[0];
      r.addr  = (k == 5) ? 32'h300 : 32'h400 + 32'(4 * k);
      r.wdata = 32'h1111_0000 + 32'(k);
      r.wstrb = 4'(k + 1);
      lsu_list.push_back(r);
      if (k == int'(STARV_MAX)) push_if(32'h108, 1'b1, 1'b1);
      push_lsu(r);
    end
    lsu_load();
    if_req = 1'b1; if_addr = 32'h108;
    drain("drain_starv");

    // flush while IF is in DATA: response dropped, next fetch normal
    resp_lat = 3;
    push_if(32'h140, 1'b1, 1'b0);
    if_req = 1'b1; if_addr = 32'h140;
    wait_hs("hs_flush_data");
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    push_if(32'h144, 1'b1, 1'b1);
    if_req = 1'b1; if_addr = 32'h144;
    drain("drain_flush_data");

    // flush in IDLE: the IF request is ignored that cycle
    resp_lat = 1;
    push_if(32'h180, 1'b1, 1'b1);
    if_req = 1'b1; if_addr = 32'h180; if_flush = 1'b1;
    tick();
    check_eq("idle_flush_no_issue", mem_valid, 1'b0);
    if_flush = 1'b0;
    drain("drain_idle_flush");

    // five-cycle stall with a flush in the middle: no if_gnt, no if_rvalid
    stall_left = 5;
    push_if(32'h1A0, 1'b0, 1'b0);
    if_req = 1'b1; if_addr = 32'h1A0;
    tick();
    check_eq("stall_issue", mem_valid, 1'b1);
    tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    drain("drain_stall_flush");

    // reset in DATA with a same-cycle memory response
    resp_lat = 3;
    push_if(32'h1C0, 1'b1, 1'b1);
    if_req = 1'b1; if_addr = 32'h1C0;
    wait_hs("hs_reset_data");
    rst = 1'b1; mp_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; mem_err = 1'b1;
    tick();
    check_all_zero("rst_in_data");
    exp_q.delete();
    cur_valid = 1'b0;
    rst = 1'b0;
    resp_lat = 1;
    push_if(32'h1C4, 1'b1, 1'b1);
    if_req = 1'b1; if_addr = 32'h1C4;
    tick();
    check_eq("post_rst_issue", mem_valid, 1'b1);
    drain("drain_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
